// File: rtl/local_bus_arb.sv
// Two-master round-robin arbiter for the shared local register bus.
// Serialises accesses, inserts a strobe-low gap and terminates hung accesses.
module local_bus_arb #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              cfg_clk_i,
    input  logic              cfg_rstn_i,
    input  logic              m0_wren_i,
    input  logic              m0_rden_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [STRB_W-1:0] m0_strb_i,
    input  logic [DATA_W-1:0] m0_wdat_i,
    output logic [DATA_W-1:0] m0_rdat_o,
    output logic              m0_rdat_vld_o,
    output logic              m0_wdat_rdy_o,
    output logic              m0_err_o,
    input  logic              m1_wren_i,
    input  logic              m1_rden_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [STRB_W-1:0] m1_strb_i,
    input  logic [DATA_W-1:0] m1_wdat_i,
    output logic [DATA_W-1:0] m1_rdat_o,
    output logic              m1_rdat_vld_o,
    output logic              m1_wdat_rdy_o,
    output logic              m1_err_o,
    output logic              local_wren_o,
    output logic              local_rden_o,
    output logic [ADDR_W-1:0] local_addr_o,
    output logic [STRB_W-1:0] local_strb_o,
    output logic [DATA_W-1:0] local_wdat_o,
    input  logic [DATA_W-1:0] local_rdat_i,
    input  logic              local_rdat_vld_i,
    input  logic              local_wdat_rdy_i
);

    localparam int CNT_W = $clog2(TIMEOUT);

    // Handshake: a master holds wren/rden (plus addr/strb/wdat) until it sees
    // exactly one single-cycle response pulse: wdat_rdy, rdat_vld or err.
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               m0_req, m1_req;
    logic               sel_wren, sel_rden, sel_req;
    logic [ADDR_W-1:0]  sel_addr;
    logic [STRB_W-1:0]  sel_strb;
    logic [DATA_W-1:0]  sel_wdat;
    logic               granted, wr_done, rd_done, tmo_hit, tmo_err;

    assign m0_req   = m0_wren_i | m0_rden_i;
    assign m1_req   = m1_wren_i | m1_rden_i;
    assign sel_wren = grant_q ? m1_wren_i : m0_wren_i;
    assign sel_rden = grant_q ? m1_rden_i : m0_rden_i;
    assign sel_addr = grant_q ? m1_addr_i : m0_addr_i;
    assign sel_strb = grant_q ? m1_strb_i : m0_strb_i;
    assign sel_wdat = grant_q ? m1_wdat_i : m0_wdat_i;
    assign sel_req  = sel_wren | sel_rden;

    // Qualified by reset so everything drops to 0 in the cycle reset is applied.
    assign granted      = cfg_rstn_i && (state_q == ST_GRANT);
    assign local_wren_o = granted & sel_wren;
    assign local_rden_o = granted & sel_rden & ~sel_wren;
    assign local_addr_o = granted ? sel_addr : '0;
    assign local_strb_o = granted ? sel_strb : '0;
    assign local_wdat_o = granted ? sel_wdat : '0;

    assign wr_done = local_wren_o & local_wdat_rdy_i;
    assign rd_done = local_rden_o & local_rdat_vld_i;
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    // A completion landing on the last count wins over the timeout.
    assign tmo_err = granted & sel_req & tmo_hit & ~wr_done & ~rd_done;

    assign m0_wdat_rdy_o = ~grant_q & wr_done;
    assign m0_rdat_vld_o = ~grant_q & rd_done;
    assign m0_rdat_o     = (~grant_q & rd_done) ? local_rdat_i : '0;
    assign m0_err_o      = ~grant_q & tmo_err;
    assign m1_wdat_rdy_o = grant_q & wr_done;
    assign m1_rdat_vld_o = grant_q & rd_done;
    assign m1_rdat_o     = (grant_q & rd_done) ? local_rdat_i : '0;
    assign m1_err_o      = grant_q & tmo_err;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                    grant_d = (m0_req & m1_req) ? ~last_grant_q : m1_req;
                end
            end
            ST_GRANT: begin
                // Any exit (done, dropped request or timeout) rotates priority.
                if (wr_done | rd_done | ~sel_req | tmo_hit) begin
                    state_d      = ST_GAP;
                    last_grant_d = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cfg_clk_i) begin
        if (!cfg_rstn_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_local_bus_arb.sv
// Directed bench for local_bus_arb: a cycle-by-cycle vector table followed by
// hand-written contention, timeout, boundary and mid-read reset sequences.
module tb_local_bus_arb;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int LW = 2 + AW + SW + DW;
    localparam int MW = 3 + DW;
    localparam logic [LW-1:0] ZL = '0;
    localparam logic [MW-1:0] ZM = '0;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_wren, m0_rden, m1_wren, m1_rden;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [SW-1:0] m0_strb, m1_strb;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          m0_vld, m0_rdy, m0_err, m1_vld, m1_rdy, m1_err;
    logic          l_wren, l_rden;
    logic [AW-1:0] l_addr;
    logic [SW-1:0] l_strb;
    logic [DW-1:0] l_wdat;
    logic [DW-1:0] s_rdat;
    logic          s_vld, s_rdy;

    int checks = 0;
    int errors = 0;

    local_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .TIMEOUT(16)) dut (
        .cfg_clk_i(clk), .cfg_rstn_i(rstn),
        .m0_wren_i(m0_wren), .m0_rden_i(m0_rden), .m0_addr_i(m0_addr),
        .m0_strb_i(m0_strb), .m0_wdat_i(m0_wdat), .m0_rdat_o(m0_rdat),
        .m0_rdat_vld_o(m0_vld), .m0_wdat_rdy_o(m0_rdy), .m0_err_o(m0_err),
        .m1_wren_i(m1_wren), .m1_rden_i(m1_rden), .m1_addr_i(m1_addr),
        .m1_strb_i(m1_strb), .m1_wdat_i(m1_wdat), .m1_rdat_o(m1_rdat),
        .m1_rdat_vld_o(m1_vld), .m1_wdat_rdy_o(m1_rdy), .m1_err_o(m1_err),
        .local_wren_o(l_wren), .local_rden_o(l_rden), .local_addr_o(l_addr),
        .local_strb_o(l_strb), .local_wdat_o(l_wdat), .local_rdat_i(s_rdat),
        .local_rdat_vld_i(s_vld), .local_wdat_rdy_i(s_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic          rstn;
        logic [1:0]    m0_op;
        logic [AW-1:0] m0_a;
        logic [DW-1:0] m0_d;
        logic [1:0]    m1_op;
        logic [AW-1:0] m1_a;
        logic [DW-1:0] m1_d;
        logic          rdy;
        logic          vld;
        logic [DW-1:0] rdat;
        logic [LW-1:0] el;
        logic [MW-1:0] e0;
        logic [MW-1:0] e1;
    } vec_t;

    vec_t vecs[22];

    function automatic logic [LW-1:0] loc(input logic wr, input logic rd,
        input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
        return {wr, rd, a, s, d};
    endfunction

    function automatic logic [MW-1:0] mres(input logic rdy, input logic vld,
        input logic err, input logic [DW-1:0] d);
        return {rdy, vld, err, d};
    endfunction

    function automatic vec_t v(input string nm, input logic r,
        input logic [1:0] o0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic [1:0] o1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic rdy, input logic vld, input logic [DW-1:0] rd,
        input logic [LW-1:0] el, input logic [MW-1:0] e0, input logic [MW-1:0] e1);
        vec_t x;
        x.nm = nm; x.rstn = r; x.m0_op = o0; x.m0_a = a0; x.m0_d = d0;
        x.m1_op = o1; x.m1_a = a1; x.m1_d = d1; x.rdy = rdy; x.vld = vld;
        x.rdat = rd; x.el = el; x.e0 = e0; x.e1 = e1;
        return x;
    endfunction

    task automatic set_m0(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        {m0_wren, m0_rden} = op; m0_addr = a; m0_wdat = d;
    endtask

    task automatic set_m1(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        {m1_wren, m1_rden} = op; m1_addr = a; m1_wdat = d;
    endtask

    task automatic set_slv(input logic rdy, input logic vld, input logic [DW-1:0] d);
        s_rdy = rdy; s_vld = vld; s_rdat = d;
    endtask

    // Inputs are already driven for this cycle; sample on the falling edge.
    task automatic cyc(input string nm, input logic [LW-1:0] el,
        input logic [MW-1:0] e0, input logic [MW-1:0] e1);
        logic [LW-1:0] al;
        logic [MW-1:0] a0, a1;
        @(negedge clk);
        al = {l_wren, l_rden, l_addr, l_strb, l_wdat};
        a0 = {m0_rdy, m0_vld, m0_err, m0_rdat};
        a1 = {m1_rdy, m1_vld, m1_err, m1_rdat};
        checks++;
        if (al !== el) begin
            errors++;
            $display("FAIL %s local_bus: got %h expected %h", nm, al, el);
        end
        checks++;
        if (a0 !== e0) begin
            errors++;
            $display("FAIL %s m0_resp: got %h expected %h", nm, a0, e0);
        end
        checks++;
        if (a1 !== e1) begin
            errors++;
            $display("FAIL %s m1_resp: got %h expected %h", nm, a1, e1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string nm);
        rstn = 1'b0;
        cyc(nm, ZL, ZM, ZM);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        m0_strb = 4'hF;
        m1_strb = 4'h3;
        set_m0(2'b00, '0, '0);
        set_m1(2'b00, '0, '0);
        set_slv(1'b0, 1'b0, '0);
        @(posedge clk);
        #1;

        // op encoding {wren, rden}
        vecs[0]  = v("rst_hold",   0, 2'b10, 30'h05, 32'hA5A5_0001, 2'b01, 30'h80, 0, 1, 1, 32'h1234_5678, ZL, ZM, ZM);
        vecs[1]  = v("wr_req",     1, 2'b10, 30'h05, 32'hA5A5_0001, 2'b00, 0, 0, 1, 0, 0, ZL, ZM, ZM);
        vecs[2]  = v("wr_grant",   1, 2'b10, 30'h05, 32'hA5A5_0001, 2'b00, 0, 0, 1, 0, 0,
                     loc(1, 0, 30'h05, 4'hF, 32'hA5A5_0001), mres(1, 0, 0, 0), ZM);
        vecs[3]  = v("wr_gap",     1, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, ZL, ZM, ZM);
        vecs[4]  = v("wr_idle",    1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);
        vecs[5]  = v("rd_req",     1, 2'b00, 0, 0, 2'b01, 30'h80, 0, 0, 1, 32'hCAFE_0000, ZL, ZM, ZM);
        vecs[6]  = v("rd_wait1",   1, 2'b00, 0, 0, 2'b01, 30'h80, 0, 0, 0, 32'hDEAD_BEEF,
                     loc(0, 1, 30'h80, 4'h3, 0), ZM, ZM);
        vecs[7]  = v("rd_wait2",   1, 2'b00, 0, 0, 2'b01, 30'h80, 0, 0, 0, 32'hDEAD_BEEF,
                     loc(0, 1, 30'h80, 4'h3, 0), ZM, ZM);
        vecs[8]  = v("rd_done",    1, 2'b00, 0, 0, 2'b01, 30'h80, 0, 0, 1, 32'h1234_5678,
                     loc(0, 1, 30'h80, 4'h3, 0), ZM, mres(0, 1, 0, 32'h1234_5678));
        vecs[9]  = v("rd_gap",     1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 32'h1111_1111, ZL, ZM, ZM);
        vecs[10] = v("rd_idle",    1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);
        vecs[11] = v("wrd_req",    1, 2'b11, 30'h07, 32'h1111_2222, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);
        vecs[12] = v("wrd_wait",   1, 2'b11, 30'h07, 32'h1111_2222, 2'b00, 0, 0, 0, 0, 0,
                     loc(1, 0, 30'h07, 4'hF, 32'h1111_2222), ZM, ZM);
        vecs[13] = v("wrd_done",   1, 2'b11, 30'h07, 32'h1111_2222, 2'b00, 0, 0, 1, 1, 32'h55,
                     loc(1, 0, 30'h07, 4'hF, 32'h1111_2222), mres(1, 0, 0, 0), ZM);
        vecs[14] = v("wrd_gap",    1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);
        vecs[15] = v("drop_req",   1, 2'b00, 0, 0, 2'b10, 30'h33, 32'h77, 0, 0, 0, ZL, ZM, ZM);
        vecs[16] = v("drop_grant", 1, 2'b00, 0, 0, 2'b10, 30'h33, 32'h77, 0, 0, 0,
                     loc(1, 0, 30'h33, 4'h3, 32'h77), ZM, ZM);
        vecs[17] = v("drop_now",   1, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0,
                     loc(0, 0, 0, 4'h3, 0), ZM, ZM);
        vecs[18] = v("drop_gap",   1, 2'b01, 30'h44, 0, 2'b00, 0, 0, 1, 1, 32'h99, ZL, ZM, ZM);
        vecs[19] = v("post_idle",  1, 2'b01, 30'h44, 0, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);
        vecs[20] = v("post_grant", 1, 2'b01, 30'h44, 0, 2'b00, 0, 0, 0, 1, 32'hBEEF,
                     loc(0, 1, 30'h44, 4'hF, 0), mres(0, 1, 0, 32'hBEEF), ZM);
        vecs[21] = v("post_gap",   1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, ZL, ZM, ZM);

        foreach (vecs[i]) begin
            rstn = vecs[i].rstn;
            set_m0(vecs[i].m0_op, vecs[i].m0_a, vecs[i].m0_d);
            set_m1(vecs[i].m1_op, vecs[i].m1_a, vecs[i].m1_d);
            set_slv(vecs[i].rdy, vecs[i].vld, vecs[i].rdat);
            cyc(vecs[i].nm, vecs[i].el, vecs[i].e0, vecs[i].e1);
        end

        // Contention: both read continuously, slave answers at once -> m0,m1,m0,m1
        set_m0(2'b01, 30'h10, 0);
        set_m1(2'b01, 30'h20, 0);
        set_slv(1'b0, 1'b1, 32'h0000_AAAA);
        reset_cycle("cont_rst");
        for (int c = 0; c < 12; c++) begin
            int who;
            who = (c / 3) % 2;
            if (c % 3 == 1) begin
                if (who == 0)
                    cyc($sformatf("cont_c%0d", c), loc(0, 1, 30'h10, 4'hF, 0),
                        mres(0, 1, 0, 32'h0000_AAAA), ZM);
                else
                    cyc($sformatf("cont_c%0d", c), loc(0, 1, 30'h20, 4'h3, 0),
                        ZM, mres(0, 1, 0, 32'h0000_AAAA));
            end else begin
                cyc($sformatf("cont_c%0d", c), ZL, ZM, ZM);
            end
        end

        // Timeout: m0 read never answered, m1 write pending behind it
        set_m0(2'b01, 30'h09, 0);
        set_m1(2'b10, 30'h20, 32'h99);
        set_slv(1'b0, 1'b0, 32'hFFFF_FFFF);
        reset_cycle("tmo_rst");
        cyc("tmo_c0", ZL, ZM, ZM);
        for (int c = 1; c <= 16; c++)
            cyc($sformatf("tmo_c%0d", c), loc(0, 1, 30'h09, 4'hF, 0),
                (c == 16) ? mres(0, 0, 1, 0) : ZM, ZM);
        set_m0(2'b00, 0, 0);
        cyc("tmo_gap", ZL, ZM, ZM);
        cyc("tmo_idle", ZL, ZM, ZM);
        set_slv(1'b1, 1'b0, 32'hFFFF_FFFF);
        cyc("tmo_m1", loc(1, 0, 30'h20, 4'h3, 32'h99), ZM, mres(1, 0, 0, 0));
        set_m1(2'b00, 0, 0);
        cyc("tmo_m1_gap", ZL, ZM, ZM);

        // Completion on the last count cycle beats the timeout
        set_m0(2'b01, 30'h09, 0);
        set_slv(1'b0, 1'b0, 32'hFFFF_FFFF);
        reset_cycle("bnd_rst");
        cyc("bnd_c0", ZL, ZM, ZM);
        for (int c = 1; c <= 15; c++)
            cyc($sformatf("bnd_c%0d", c), loc(0, 1, 30'h09, 4'hF, 0), ZM, ZM);
        set_slv(1'b0, 1'b1, 32'h0BAD_F00D);
        cyc("bnd_c16", loc(0, 1, 30'h09, 4'hF, 0), mres(0, 1, 0, 32'h0BAD_F00D), ZM);
        set_m0(2'b00, 0, 0);
        cyc("bnd_gap", ZL, ZM, ZM);

        // Reset in cycle 2 of an m1 read, then a tie goes to m0
        set_m1(2'b01, 30'h80, 0);
        set_slv(1'b0, 1'b0, 0);
        reset_cycle("mrst_rst");
        cyc("mrst_c0", ZL, ZM, ZM);
        cyc("mrst_c1", loc(0, 1, 30'h80, 4'h3, 0), ZM, ZM);
        rstn = 1'b0;
        set_slv(1'b0, 1'b1, 32'h1234_5678);
        cyc("mrst_c2", ZL, ZM, ZM);
        rstn = 1'b1;
        set_slv(1'b0, 1'b0, 0);
        set_m0(2'b01, 30'h10, 0);
        cyc("mrst_c3", ZL, ZM, ZM);
        cyc("mrst_c4", loc(0, 1, 30'h10, 4'hF, 0), ZM, ZM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
